// File: rtl/fetch_mem_arbiter.sv
// ============================================================================
// Module   : fetch_mem_arbiter
// Purpose  : Round-robin arbiter sharing one memory port between icache fills
//            and dcache loads/stores, with tag-indexed response routing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_mem_arbiter #(
    parameter int TAG_W     = 4,
    parameter int MAX_OUT_I = 4,
    parameter int MAX_OUT_D = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ic_req_i,
    input  logic [31:0]      ic_addr_i,
    output logic             ic_ack_o,
    output logic             ic_resp_valid_o,
    output logic [63:0]      ic_resp_data_o,
    output logic [31:0]      ic_resp_addr_o,
    input  logic             ic_flush_i,
    input  logic             dc_req_i,
    input  logic [1:0]       dc_cmd_i,
    input  logic [31:0]      dc_addr_i,
    input  logic [63:0]      dc_wdata_i,
    output logic             dc_ack_o,
    output logic             dc_resp_valid_o,
    output logic [63:0]      dc_resp_data_o,
    output logic [TAG_W-1:0] dc_resp_tag_o,
    output logic [1:0]       proc2mem_command_o,
    output logic [31:0]      proc2mem_addr_o,
    output logic [63:0]      proc2mem_data_o,
    input  logic [TAG_W-1:0] mem2proc_transaction_tag_i,
    input  logic [63:0]      mem2proc_data_i,
    input  logic [TAG_W-1:0] mem2proc_data_tag_i,
    output logic             err_o
);

    localparam int         c_NUM_TAGS  = 1 << TAG_W;
    localparam int         c_CI_W      = $clog2(MAX_OUT_I + 1);
    localparam int         c_CD_W      = $clog2(MAX_OUT_D + 1);
    localparam logic [1:0] c_MEM_NONE  = 2'd0;
    localparam logic [1:0] c_MEM_LOAD  = 2'd1;
    localparam logic [1:0] c_MEM_STORE = 2'd2;
    localparam logic       c_OWN_I     = 1'b0;
    localparam logic       c_OWN_D     = 1'b1;

    logic [c_NUM_TAGS-1:0] r_valid;
    logic [c_NUM_TAGS-1:0] r_owner;
    logic [c_NUM_TAGS-1:0] r_drop;
    logic [31:0]           r_addr [c_NUM_TAGS];
    logic [c_CI_W-1:0]     r_cnt_i;
    logic [c_CD_W-1:0]     r_cnt_d;
    logic                  r_rr_ptr;
    logic                  r_post_reset;

    logic [TAG_W:0] w_free_cnt;
    logic           w_ic_elig, w_dc_elig, w_grant_i, w_grant_d;
    logic           w_accept, w_acc_load, w_inc_i, w_inc_d;
    logic           w_rsp_any, w_rsp_hit, w_rsp_own, w_rsp_drop, w_dec_i, w_dec_d;
    logic           w_err_next;

    // Tag 0 is reserved as "no tag", so only entries 1..N-1 are allocatable.
    always_comb begin
        w_free_cnt = '0;
        for (int t = 1; t < c_NUM_TAGS; t++) begin
            w_free_cnt = w_free_cnt + {{TAG_W{1'b0}}, ~r_valid[t]};
        end
    end

    assign w_ic_elig = !reset && ic_req_i && !ic_flush_i && (w_free_cnt != '0)
                       && (r_cnt_i < c_CI_W'(MAX_OUT_I));
    assign w_dc_elig = !reset && dc_req_i && (w_free_cnt != '0)
                       && ((dc_cmd_i == c_MEM_STORE) || (r_cnt_d < c_CD_W'(MAX_OUT_D)));
    assign w_grant_i = w_ic_elig && (!w_dc_elig || (r_rr_ptr == c_OWN_I));
    assign w_grant_d = w_dc_elig && !w_grant_i;

    always_comb begin
        proc2mem_command_o = c_MEM_NONE;
        proc2mem_addr_o    = '0;
        proc2mem_data_o    = '0;
        if (w_grant_i) begin
            proc2mem_command_o = c_MEM_LOAD;
            proc2mem_addr_o    = ic_addr_i;
        end else if (w_grant_d) begin
            proc2mem_command_o = dc_cmd_i;
            proc2mem_addr_o    = dc_addr_i;
            proc2mem_data_o    = dc_wdata_i;
        end
    end

    assign w_accept   = (w_grant_i || w_grant_d) && (mem2proc_transaction_tag_i != '0);
    assign ic_ack_o   = w_grant_i && w_accept;
    assign dc_ack_o   = w_grant_d && w_accept;
    assign w_acc_load = w_accept && (w_grant_i || (dc_cmd_i != c_MEM_STORE));
    assign w_inc_i    = w_acc_load && w_grant_i;
    assign w_inc_d    = w_acc_load && w_grant_d;

    // A fill returning in the flush cycle belongs to the squashed path too.
    assign w_rsp_any  = (mem2proc_data_tag_i != '0);
    assign w_rsp_hit  = w_rsp_any && r_valid[mem2proc_data_tag_i];
    assign w_rsp_own  = r_owner[mem2proc_data_tag_i];
    assign w_rsp_drop = r_drop[mem2proc_data_tag_i] || ((w_rsp_own == c_OWN_I) && ic_flush_i);
    assign w_dec_i    = w_rsp_hit && (w_rsp_own == c_OWN_I);
    assign w_dec_d    = w_rsp_hit && (w_rsp_own == c_OWN_D);

    assign w_err_next = (w_acc_load && r_valid[mem2proc_transaction_tag_i]
                         && !(w_rsp_hit && (mem2proc_data_tag_i == mem2proc_transaction_tag_i)))
                      || (w_rsp_any && !r_valid[mem2proc_data_tag_i] && !r_post_reset)
                      || (w_dec_i && (r_cnt_i == '0))
                      || (w_dec_d && (r_cnt_d == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid         <= '0;
            r_owner         <= '0;
            r_drop          <= '0;
            for (int t = 0; t < c_NUM_TAGS; t++) r_addr[t] <= '0;
            r_cnt_i         <= '0;
            r_cnt_d         <= '0;
            r_rr_ptr        <= c_OWN_I;
            r_post_reset    <= 1'b1;
            err_o           <= 1'b0;
            ic_resp_valid_o <= 1'b0;
            ic_resp_data_o  <= '0;
            ic_resp_addr_o  <= '0;
            dc_resp_valid_o <= 1'b0;
            dc_resp_data_o  <= '0;
            dc_resp_tag_o   <= '0;
        end else begin
            if (!w_rsp_any) r_post_reset <= 1'b0;
            if (w_err_next) err_o <= 1'b1;
            if (w_accept)   r_rr_ptr <= w_grant_i ? c_OWN_D : c_OWN_I;

            for (int t = 0; t < c_NUM_TAGS; t++) begin
                if (ic_flush_i && r_valid[t] && (r_owner[t] == c_OWN_I)) r_drop[t] <= 1'b1;
            end
            // Free first so a same-cycle accept on the same tag re-allocates it.
            if (w_rsp_hit) r_valid[mem2proc_data_tag_i] <= 1'b0;
            if (w_acc_load) begin
                r_valid[mem2proc_transaction_tag_i] <= 1'b1;
                r_owner[mem2proc_transaction_tag_i] <= w_grant_i ? c_OWN_I : c_OWN_D;
                r_drop[mem2proc_transaction_tag_i]  <= 1'b0;
                r_addr[mem2proc_transaction_tag_i]  <= proc2mem_addr_o;
            end

            case ({w_inc_i, w_dec_i})
                2'b10:   r_cnt_i <= r_cnt_i + c_CI_W'(1);
                2'b01:   if (r_cnt_i != '0) r_cnt_i <= r_cnt_i - c_CI_W'(1);
                default: ;
            endcase
            case ({w_inc_d, w_dec_d})
                2'b10:   r_cnt_d <= r_cnt_d + c_CD_W'(1);
                2'b01:   if (r_cnt_d != '0) r_cnt_d <= r_cnt_d - c_CD_W'(1);
                default: ;
            endcase

            ic_resp_valid_o <= w_dec_i && !w_rsp_drop;
            dc_resp_valid_o <= w_dec_d && !w_rsp_drop;
            if (w_dec_i && !w_rsp_drop) begin
                ic_resp_data_o <= mem2proc_data_i;
                ic_resp_addr_o <= r_addr[mem2proc_data_tag_i];
            end
            if (w_dec_d && !w_rsp_drop) begin
                dc_resp_data_o <= mem2proc_data_i;
                dc_resp_tag_o  <= mem2proc_data_tag_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_mem_arbiter.sv
// ============================================================================
// Module   : tb_fetch_mem_arbiter
// Purpose  : Directed self-checking bench for fetch_mem_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ic_req_i, ic_flush_i, dc_req_i;
    logic [31:0] ic_addr_i, dc_addr_i;
    logic [1:0]  dc_cmd_i;
    logic [63:0] dc_wdata_i, mem2proc_data_i;
    logic [3:0]  mem2proc_transaction_tag_i, mem2proc_data_tag_i;
    logic        ic_ack_o, ic_resp_valid_o, dc_ack_o, dc_resp_valid_o, err_o;
    logic [63:0] ic_resp_data_o, dc_resp_data_o, proc2mem_data_o;
    logic [31:0] ic_resp_addr_o, proc2mem_addr_o;
    logic [3:0]  dc_resp_tag_o;
    logic [1:0]  proc2mem_command_o;

    int checks   = 0;
    int failures = 0;

    fetch_mem_arbiter #(.TAG_W(4), .MAX_OUT_I(4), .MAX_OUT_D(8)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .ic_req_i                   (ic_req_i),
        .ic_addr_i                  (ic_addr_i),
        .ic_ack_o                   (ic_ack_o),
        .ic_resp_valid_o            (ic_resp_valid_o),
        .ic_resp_data_o             (ic_resp_data_o),
        .ic_resp_addr_o             (ic_resp_addr_o),
        .ic_flush_i                 (ic_flush_i),
        .dc_req_i                   (dc_req_i),
        .dc_cmd_i                   (dc_cmd_i),
        .dc_addr_i                  (dc_addr_i),
        .dc_wdata_i                 (dc_wdata_i),
        .dc_ack_o                   (dc_ack_o),
        .dc_resp_valid_o            (dc_resp_valid_o),
        .dc_resp_data_o             (dc_resp_data_o),
        .dc_resp_tag_o              (dc_resp_tag_o),
        .proc2mem_command_o         (proc2mem_command_o),
        .proc2mem_addr_o            (proc2mem_addr_o),
        .proc2mem_data_o            (proc2mem_data_o),
        .mem2proc_transaction_tag_i (mem2proc_transaction_tag_i),
        .mem2proc_data_i            (mem2proc_data_i),
        .mem2proc_data_tag_i        (mem2proc_data_tag_i),
        .err_o                      (err_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the rising edge; combinational outputs
    // are sampled 2 units later, registered outputs right after tick().
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        ic_req_i = 0; ic_addr_i = '0; ic_flush_i = 0;
        dc_req_i = 0; dc_cmd_i = 2'd0; dc_addr_i = '0; dc_wdata_i = '0;
        mem2proc_transaction_tag_i = '0; mem2proc_data_i = '0; mem2proc_data_tag_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        ic_req_i = 1; ic_addr_i = 32'h1000; mem2proc_transaction_tag_i = 4'd1;
        tick(); tick();
        settle();
        checks++; if (ic_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ic_ack: got %b want 0", ic_ack_o); end
        reset = 0;
        idle_inputs();
        tick();
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_o); end
        checks++; if (ic_resp_valid_o !== 1'b0 || dc_resp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valids: got %b%b want 00", ic_resp_valid_o, dc_resp_valid_o); end
        checks++; if (proc2mem_command_o !== 2'd0) begin failures++; $display("FAIL reset_cmd: got %0d want 0", proc2mem_command_o); end
        checks++; if (dut.r_rr_ptr !== 1'b0) begin failures++; $display("FAIL reset_rr: got %b want 0", dut.r_rr_ptr); end
    endtask

    task automatic test_ic_load();
        do_reset();
        ic_req_i = 1; ic_addr_i = 32'h1000; mem2proc_transaction_tag_i = 4'd3;
        settle();
        checks++; if (ic_ack_o !== 1'b1) begin failures++; $display("FAIL ic_load_ack: got %b want 1", ic_ack_o); end
        checks++; if (proc2mem_command_o !== 2'd1 || proc2mem_addr_o !== 32'h1000) begin failures++; $display("FAIL ic_load_bus: got cmd %0d addr %h want 1 00001000", proc2mem_command_o, proc2mem_addr_o); end
        tick();
        idle_inputs();
        checks++; if (dut.r_cnt_i !== 3'd1) begin failures++; $display("FAIL ic_load_cnt_up: got %0d want 1", dut.r_cnt_i); end
        tick();
        mem2proc_data_tag_i = 4'd3; mem2proc_data_i = 64'hDEAD_BEEF;
        settle();
        checks++; if (ic_resp_valid_o !== 1'b0) begin failures++; $display("FAIL ic_load_early: got %b want 0", ic_resp_valid_o); end
        tick();
        mem2proc_data_tag_i = '0; mem2proc_data_i = '0;
        checks++; if (ic_resp_valid_o !== 1'b1) begin failures++; $display("FAIL ic_load_valid: got %b want 1", ic_resp_valid_o); end
        checks++; if (ic_resp_data_o !== 64'hDEAD_BEEF || ic_resp_addr_o !== 32'h1000) begin failures++; $display("FAIL ic_load_data: got %h @%h want deadbeef @00001000", ic_resp_data_o, ic_resp_addr_o); end
        checks++; if (dc_resp_valid_o !== 1'b0) begin failures++; $display("FAIL ic_load_dc_quiet: got %b want 0", dc_resp_valid_o); end
        checks++; if (dut.r_cnt_i !== 3'd0) begin failures++; $display("FAIL ic_load_cnt_down: got %0d want 0", dut.r_cnt_i); end
        tick();
        checks++; if (ic_resp_valid_o !== 1'b0) begin failures++; $display("FAIL ic_load_pulse: got %b want 0", ic_resp_valid_o); end
    endtask

    task automatic test_round_robin();
        do_reset();
        ic_req_i = 1; ic_addr_i = 32'h2000;
        dc_req_i = 1; dc_cmd_i = 2'd1; dc_addr_i = 32'h3000;
        for (int k = 0; k < 4; k++) begin
            logic        exp_i;
            logic [31:0] exp_addr;
            exp_i    = (k % 2 == 0);
            exp_addr = exp_i ? 32'h2000 : 32'h3000;
            mem2proc_transaction_tag_i = 4'(k + 1);
            settle();
            checks++; if (ic_ack_o !== exp_i || dc_ack_o !== !exp_i) begin failures++; $display("FAIL rr_grant[%0d]: got ic %b dc %b want ic %b", k, ic_ack_o, dc_ack_o, exp_i); end
            checks++; if (proc2mem_addr_o !== exp_addr) begin failures++; $display("FAIL rr_addr[%0d]: got %h want %h", k, proc2mem_addr_o, exp_addr); end
            tick();
        end
        idle_inputs();
        checks++; if (dut.r_cnt_i !== 3'd2 || dut.r_cnt_d !== 4'd2) begin failures++; $display("FAIL rr_counts: got %0d/%0d want 2/2", dut.r_cnt_i, dut.r_cnt_d); end
    endtask

    task automatic test_dc_load();
        do_reset();
        dc_req_i = 1; dc_cmd_i = 2'd1; dc_addr_i = 32'h7000; mem2proc_transaction_tag_i = 4'd4;
        settle();
        checks++; if (dc_ack_o !== 1'b1) begin failures++; $display("FAIL dc_load_ack: got %b want 1", dc_ack_o); end
        tick();
        idle_inputs();
        mem2proc_data_tag_i = 4'd4; mem2proc_data_i = 64'h55AA_0011_2233_4455;
        tick();
        mem2proc_data_tag_i = '0;
        checks++; if (dc_resp_valid_o !== 1'b1 || ic_resp_valid_o !== 1'b0) begin failures++; $display("FAIL dc_load_valid: got dc %b ic %b want 1 0", dc_resp_valid_o, ic_resp_valid_o); end
        checks++; if (dc_resp_tag_o !== 4'd4 || dc_resp_data_o !== 64'h55AA_0011_2233_4455) begin failures++; $display("FAIL dc_load_data: got tag %0d data %h", dc_resp_tag_o, dc_resp_data_o); end
        checks++; if (dut.r_cnt_d !== 4'd0) begin failures++; $display("FAIL dc_load_cnt: got %0d want 0", dut.r_cnt_d); end
    endtask

    task automatic test_store_stall();
        do_reset();
        dc_req_i = 1; dc_cmd_i = 2'd2; dc_addr_i = 32'h4000; dc_wdata_i = 64'h1234_5678_9ABC_DEF0;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (dc_ack_o !== 1'b0) begin failures++; $display("FAIL store_stall_ack[%0d]: got %b want 0", k, dc_ack_o); end
            checks++; if (proc2mem_command_o !== 2'd2 || proc2mem_data_o !== 64'h1234_5678_9ABC_DEF0) begin failures++; $display("FAIL store_stall_bus[%0d]: got cmd %0d data %h", k, proc2mem_command_o, proc2mem_data_o); end
            tick();
            checks++; if (dut.r_rr_ptr !== 1'b0) begin failures++; $display("FAIL store_stall_rr[%0d]: got %b want 0", k, dut.r_rr_ptr); end
        end
        mem2proc_transaction_tag_i = 4'd5;
        settle();
        checks++; if (dc_ack_o !== 1'b1) begin failures++; $display("FAIL store_ack: got %b want 1", dc_ack_o); end
        tick();
        idle_inputs();
        checks++; if (dut.r_valid[5] !== 1'b0 || dut.r_cnt_d !== 4'd0) begin failures++; $display("FAIL store_no_alloc: got valid %b cnt %0d want 0 0", dut.r_valid[5], dut.r_cnt_d); end
        checks++; if (dut.r_rr_ptr !== 1'b0) begin failures++; $display("FAIL store_rr_flip: got %b want 0 (icache next)", dut.r_rr_ptr); end
    endtask

    task automatic test_cap();
        do_reset();
        ic_req_i = 1; ic_addr_i = 32'h5000;
        for (int k = 1; k <= 4; k++) begin
            mem2proc_transaction_tag_i = 4'(k);
            tick();
        end
        dc_req_i = 1; dc_cmd_i = 2'd1; dc_addr_i = 32'h6000; mem2proc_transaction_tag_i = 4'd5;
        settle();
        checks++; if (ic_ack_o !== 1'b0 || dc_ack_o !== 1'b1) begin failures++; $display("FAIL cap_block: got ic %b dc %b want 0 1", ic_ack_o, dc_ack_o); end
        checks++; if (proc2mem_addr_o !== 32'h6000) begin failures++; $display("FAIL cap_addr: got %h want 00006000", proc2mem_addr_o); end
        tick();
        dc_req_i = 0; mem2proc_transaction_tag_i = 4'd6;
        mem2proc_data_tag_i = 4'd2; mem2proc_data_i = 64'h2222;
        settle();
        checks++; if (ic_ack_o !== 1'b0) begin failures++; $display("FAIL cap_still_full: got %b want 0", ic_ack_o); end
        tick();
        mem2proc_data_tag_i = '0;
        settle();
        checks++; if (ic_resp_valid_o !== 1'b1 || ic_resp_addr_o !== 32'h5000) begin failures++; $display("FAIL cap_resp: got %b @%h want 1 @00005000", ic_resp_valid_o, ic_resp_addr_o); end
        checks++; if (ic_ack_o !== 1'b1) begin failures++; $display("FAIL cap_reopen: got %b want 1", ic_ack_o); end
        tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        ic_req_i = 1; ic_addr_i = 32'h8000; mem2proc_transaction_tag_i = 4'd6;
        tick();
        mem2proc_transaction_tag_i = 4'd7;
        tick();
        mem2proc_transaction_tag_i = 4'd8; ic_flush_i = 1;
        settle();
        checks++; if (ic_ack_o !== 1'b0 || proc2mem_command_o !== 2'd0) begin failures++; $display("FAIL flush_no_grant: got ack %b cmd %0d want 0 0", ic_ack_o, proc2mem_command_o); end
        tick();
        idle_inputs();
        mem2proc_data_tag_i = 4'd6; mem2proc_data_i = 64'h6666;
        tick();
        mem2proc_data_tag_i = 4'd7; mem2proc_data_i = 64'h7777;
        checks++; if (ic_resp_valid_o !== 1'b0) begin failures++; $display("FAIL flush_drop6: got %b want 0", ic_resp_valid_o); end
        tick();
        mem2proc_data_tag_i = '0;
        checks++; if (ic_resp_valid_o !== 1'b0) begin failures++; $display("FAIL flush_drop7: got %b want 0", ic_resp_valid_o); end
        checks++; if (dut.r_cnt_i !== 3'd0 || dut.r_valid[6] !== 1'b0 || dut.r_valid[7] !== 1'b0) begin failures++; $display("FAIL flush_freed: got cnt %0d v6 %b v7 %b", dut.r_cnt_i, dut.r_valid[6], dut.r_valid[7]); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL flush_err: got %b want 0", err_o); end
        // A fill returning in the flush cycle itself is also discarded.
        ic_req_i = 1; ic_addr_i = 32'h9000; mem2proc_transaction_tag_i = 4'd1;
        tick();
        idle_inputs();
        ic_flush_i = 1; mem2proc_data_tag_i = 4'd1; mem2proc_data_i = 64'h1111;
        tick();
        idle_inputs();
        checks++; if (ic_resp_valid_o !== 1'b0 || dut.r_cnt_i !== 3'd0) begin failures++; $display("FAIL flush_same_cycle: got valid %b cnt %0d want 0 0", ic_resp_valid_o, dut.r_cnt_i); end
    endtask

    task automatic test_post_reset();
        do_reset();
        ic_req_i = 1; ic_addr_i = 32'hA000; mem2proc_transaction_tag_i = 4'd2;
        tick();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        mem2proc_data_tag_i = 4'd2; mem2proc_data_i = 64'hABCD;
        tick();
        mem2proc_data_tag_i = '0;
        checks++; if (err_o !== 1'b0 || ic_resp_valid_o !== 1'b0) begin failures++; $display("FAIL post_reset_stale: got err %b valid %b want 0 0", err_o, ic_resp_valid_o); end
        tick();
    endtask

    task automatic test_bad_tag();
        do_reset();
        tick();
        mem2proc_data_tag_i = 4'd9; mem2proc_data_i = 64'h9999;
        tick();
        mem2proc_data_tag_i = '0;
        checks++; if (ic_resp_valid_o !== 1'b0 || dc_resp_valid_o !== 1'b0) begin failures++; $display("FAIL bad_tag_valid: got ic %b dc %b want 0 0", ic_resp_valid_o, dc_resp_valid_o); end
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL bad_tag_err: got %b want 1", err_o); end
        tick(); tick(); tick();
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL bad_tag_sticky: got %b want 1", err_o); end
        do_reset();
        tick();
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL bad_tag_cleared: got %b want 0", err_o); end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_ic_load();
        test_round_robin();
        test_dc_load();
        test_store_stall();
        test_cap();
        test_flush();
        test_post_reset();
        test_bad_tag();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
